// File: rtl/mul32_shift_add.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one step per clock.
// Each step uses the external ripple adder through the add_* ports.
module mul32_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_c0,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_co
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] mcand_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;

    // Next-state decode; DONE always lasts exactly one cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_STEP) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered busy/done flags that track the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Datapath: operand capture on accepted start, one shift-add step per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r    <= '0;
            lo_r    <= '0;
            mcand_r <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        hi_r    <= '0;
                        lo_r    <= mplier;
                        mcand_r <= mcand;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    // Adder carry becomes the new hi MSB so the full 2*WIDTH result is kept
                    hi_r  <= {add_co, add_s[WIDTH-1:1]};
                    lo_r  <= {add_s[0], lo_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CW'(1);
                end
                default: begin
                    hi_r <= hi_r;
                end
            endcase
        end
    end

    assign add_a   = hi_r;
    assign add_b   = lo_r[0] ? mcand_r : {WIDTH{1'b0}};
    assign add_c0  = 1'b0;
    assign product = {hi_r, lo_r};
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_mul32_shift_add.sv
// Self-checking bench for mul32_shift_add; models the external adder and compares
// products against plain 64-bit multiplication.
module tb_mul32_shift_add;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_c0;
    logic [31:0] add_s;
    logic        add_co;

    int vectors;
    int miscompares;

    mul32_shift_add #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .product(product),
        .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
        .add_s(add_s), .add_co(add_co)
    );

    // External ripple adder stand-in
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Runs one multiply; optionally re-pulses start with 7*9 at cycle pulse_at.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                          output logic [63:0] prod, output int cyc, output int busy_n);
        @(negedge clk);
        mcand = a; mplier = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; mcand = $urandom; mplier = $urandom;
        cyc = 0; busy_n = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
            if (cyc == pulse_at) begin
                start = 1'b1; mcand = 32'd7; mplier = 32'd9;
            end else if (cyc == pulse_at + 1) begin
                start = 1'b0;
            end
        end while (!done && cyc < 100);
        prod = product;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mcand = 32'd0; mplier = 32'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0 || add_a !== 32'd0 ||
            add_b !== 32'd0 || add_c0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b product=%h add_a=%h add_b=%h add_c0=%b, required all zero",
                     busy, done, product, add_a, add_b, add_c0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] p; int cyc; int bn;
        do_mul(32'd3, 32'd5, -10, p, cyc, bn);
        vectors++;
        if (p !== 64'h0000_0000_0000_000F) begin
            miscompares++; $display("FAIL basic_3x5: product=%h required %h", p, 64'hF);
        end
        vectors++;
        if (cyc !== 33) begin
            miscompares++; $display("FAIL basic_latency: done at cycle %0d required 33", cyc);
        end
        vectors++;
        if (bn !== 32) begin
            miscompares++; $display("FAIL basic_busy_cycles: busy for %0d cycles required 32", bn);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_busy_at_done: busy=%b required 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || product !== 64'hF) begin
            miscompares++;
            $display("FAIL basic_after_done: done=%b product=%h required done=0 product=f", done, product);
        end
    endtask

    task automatic test_all_ones();
        logic [63:0] p; int cyc; int bn;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, -10, p, cyc, bn);
        vectors++;
        if (p !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++; $display("FAIL all_ones: product=%h required %h", p, 64'hFFFF_FFFE_0000_0001);
        end
    endtask

    task automatic test_patterns();
        logic [63:0] p; int cyc; int bn;
        do_mul(32'h0001_0000, 32'h0001_0000, -10, p, cyc, bn);
        vectors++;
        if (p !== 64'h0000_0001_0000_0000) begin
            miscompares++; $display("FAIL pow2: product=%h required %h", p, 64'h0000_0001_0000_0000);
        end
        do_mul(32'd0, 32'hAAAA_AAAA, -10, p, cyc, bn);
        vectors++;
        if (p !== 64'd0 || cyc !== 33) begin
            miscompares++; $display("FAIL zero_mcand: product=%h cycle=%0d required 0 at cycle 33", p, cyc);
        end
    endtask

    task automatic test_restart_ignored();
        logic [63:0] p; int cyc; int bn;
        do_mul(32'd3, 32'd5, 10, p, cyc, bn);
        vectors++;
        if (p !== 64'd15 || cyc !== 33) begin
            miscompares++; $display("FAIL restart_ignored: product=%0d cycle=%0d required 15 at 33", p, cyc);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (product !== 64'd15 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_hold: product=%0d busy=%b done=%b required 15/0/0", product, busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] p; int cyc; int bn; int stray;
        @(negedge clk);
        mcand = 32'hFFFF_FFFF; mplier = 32'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: busy=%b done=%b product=%h required 0/0/0", busy, done, product);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++; $display("FAIL reset_no_stray: %0d cycles with busy/done, required 0", stray);
        end
        do_mul(32'd6, 32'd7, -10, p, cyc, bn);
        vectors++;
        if (p !== 64'd42 || cyc !== 33) begin
            miscompares++; $display("FAIL after_reset_6x7: product=%0d cycle=%0d required 42 at 33", p, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int t; int last; int pulses;
        t = 0; last = -1; pulses = 0;
        @(negedge clk);
        mcand = 32'd2; mplier = 32'd3; start = 1'b1;
        while (pulses < 3 && t < 300) begin
            @(negedge clk);
            t++;
            vectors++;
            if (add_b !== (product[0] ? 32'd2 : 32'd0) || add_c0 !== 1'b0 || add_a !== product[63:32]) begin
                miscompares++;
                $display("FAIL adder_drive t=%0d: add_a=%h add_b=%h add_c0=%b lo0=%b required a=%h b=%h c0=0",
                         t, add_a, add_b, add_c0, product[0], product[63:32], product[0] ? 32'd2 : 32'd0);
            end
            if (done) begin
                vectors++;
                if (product !== 64'd6) begin
                    miscompares++; $display("FAIL b2b_product: product=%0d required 6", product);
                end
                if (last >= 0) begin
                    vectors++;
                    if (t - last !== 34) begin
                        miscompares++; $display("FAIL b2b_period: %0d cycles between done pulses required 34", t - last);
                    end
                end
                last = t;
                pulses++;
            end
        end
        start = 1'b0;
        vectors++;
        if (pulses !== 3) begin
            miscompares++; $display("FAIL b2b_pulses: saw %0d done pulses required 3", pulses);
        end
    endtask

    task automatic test_random();
        logic [63:0] p; int cyc; int bn; logic [31:0] a; logic [31:0] b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom;
            if (i == 0) a = 32'h8000_0001;
            do_mul(a, b, -10, p, cyc, bn);
            vectors++;
            if (p !== ref_mul(a, b) || cyc !== 33) begin
                miscompares++;
                $display("FAIL random_%0d %h*%h: product=%h cycle=%0d required %h at 33",
                         i, a, b, p, cyc, ref_mul(a, b));
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_all_ones();
        test_patterns();
        test_restart_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
